// File: rtl/adc_pattern_seq.sv
// Purpose: two-channel ADC sample sequencer (pattern table, ramp or pass-through) with arm/trigger/stop and loop count.
// Latency: 2 adc_clk cycles. The pointer or captured ext word goes through a read/select register, then the output register.
// Backpressure: none. The outputs stream every cycle while dat_vld_o is high. Define ADC_PAT_INV_EN to enable ADC line coding.
module adc_pattern_seq #(
   parameter int DW = 14,
   parameter int AW = 10,
   parameter int LW = 16
) (
   input  logic          adc_clk_i,
   input  logic          adc_rstn_i,
   input  logic [1:0]    cfg_mode_i,
   input  logic [AW-1:0] cfg_len_i,
   input  logic [AW-1:0] cfg_ofs0_i,
   input  logic [AW-1:0] cfg_ofs1_i,
   input  logic [LW-1:0] cfg_loops_i,
   input  logic          start_i,
   input  logic          trig_i,
   input  logic          stop_i,
   input  logic          tbl_we_i,
   input  logic [AW-1:0] tbl_addr_i,
   input  logic [DW-1:0] tbl_wdata_i,
   input  logic [DW-1:0] ext_dat0_i,
   input  logic [DW-1:0] ext_dat1_i,
   output logic [DW-1:0] dat0_o,
   output logic [DW-1:0] dat1_o,
   output logic          dat_vld_o,
   output logic          busy_o,
   output logic          done_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_TABLE = 2'b01;
   localparam logic [1:0] MODE_RAMP  = 2'b10;

   state_t        state;
   state_t        state_nxt;
   logic          cfg_load;
   logic          run_load;
   logic          last_wrap;

   // configuration captured when the sequencer is armed
   logic [1:0]    mode_q;
   logic [AW-1:0] len_q;
   logic [AW-1:0] ofs0_q;
   logic [AW-1:0] ofs1_q;
   logic [LW-1:0] loops_q;

   // read pointers and loop counter
   logic [AW-1:0] rp0;
   logic [AW-1:0] rp1;
   logic [AW-1:0] len_m1;
   logic [AW-1:0] start0;
   logic [AW-1:0] start1;
   logic          rp0_wrap;
   logic          rp1_wrap;
   logic [LW-1:0] loop_cnt;

   // pattern table, not reset
   logic [DW-1:0] mem [2**AW];

   // pipeline
   logic [DW-1:0] ext0_q;
   logic [DW-1:0] ext1_q;
   logic [DW-1:0] sel0;
   logic [DW-1:0] sel1;
   logic [DW-1:0] s1_dat0;
   logic [DW-1:0] s1_dat1;
   logic          s1_vld;
   logic [DW-1:0] dat0_q;
   logic [DW-1:0] dat1_q;
   logic          vld_q;

   // Zero-extend or truncate a pointer to sample width.
   function automatic logic [DW-1:0] ramp_word(input logic [AW-1:0] p);
      ramp_word = '0;
      for (int i = 0; i < DW && i < AW; i++) begin
         ramp_word[i] = p[i];
      end
   endfunction

   // Output line coding. With ADC_PAT_INV_EN the MSB is kept and the remaining bits are inverted.
   function automatic logic [DW-1:0] line_code(input logic [DW-1:0] d);
`ifdef ADC_PAT_INV_EN
      line_code = {d[DW-1], ~d[DW-2:0]};
`else
      line_code = d;
`endif
   endfunction

   assign len_m1   = len_q - AW'(1);
   assign rp0_wrap = (rp0 == len_m1);
   assign rp1_wrap = (rp1 == len_m1);
   // An offset that falls outside the pattern restarts that channel at address 0.
   assign start0   = (ofs0_q >= len_q) ? '0 : ofs0_q;
   assign start1   = (ofs1_q >= len_q) ? '0 : ofs1_q;
   // The channel-0 wrap that brings the count up to loops_q ends the run. It ends on the next edge.
   assign last_wrap = (state == ST_RUN) && rp0_wrap && (loops_q != '0) &&
                      ((loop_cnt + LW'(1)) == loops_q);

   // State register.
   always_ff @(posedge adc_clk_i) begin
      if (!adc_rstn_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs. stop_i has priority over start_i and trig_i.
   always_comb begin
      state_nxt = state;
      cfg_load  = 1'b0;
      run_load  = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!stop_i && start_i && (cfg_len_i != '0)) begin
               state_nxt = ST_ARMED;
               cfg_load  = 1'b1;
            end
         end
         ST_ARMED: begin
            busy_o = 1'b1;
            if (stop_i) begin
               state_nxt = ST_IDLE;
            end else if (trig_i) begin
               state_nxt = ST_RUN;
               run_load  = 1'b1;
            end
         end
         ST_RUN: begin
            busy_o = 1'b1;
            if (stop_i || last_wrap) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latch the configuration on arming so it cannot change during a run.
   always_ff @(posedge adc_clk_i) begin
      if (!adc_rstn_i) begin
         mode_q  <= '0;
         len_q   <= '0;
         ofs0_q  <= '0;
         ofs1_q  <= '0;
         loops_q <= '0;
      end else if (cfg_load) begin
         mode_q  <= cfg_mode_i;
         len_q   <= cfg_len_i;
         ofs0_q  <= cfg_ofs0_i;
         ofs1_q  <= cfg_ofs1_i;
         loops_q <= cfg_loops_i;
      end
   end

   // Pointers load their start addresses on the trigger, then advance every RUN cycle.
   always_ff @(posedge adc_clk_i) begin
      if (!adc_rstn_i) begin
         rp0      <= '0;
         rp1      <= '0;
         loop_cnt <= '0;
      end else if (run_load) begin
         rp0      <= start0;
         rp1      <= start1;
         loop_cnt <= '0;
      end else if (state == ST_RUN) begin
         rp0 <= rp0_wrap ? '0 : rp0 + AW'(1);
         rp1 <= rp1_wrap ? '0 : rp1 + AW'(1);
         if (rp0_wrap) begin
            loop_cnt <= loop_cnt + LW'(1);
         end
      end
   end

   // Table write port. It is open in every state. Reads in the same edge see the old word.
   always_ff @(posedge adc_clk_i) begin
      if (tbl_we_i) begin
         mem[tbl_addr_i] <= tbl_wdata_i;
      end
   end

   // Source select for both channels. Mode 00 and mode 11 pass the external words through.
   always_comb begin
      sel0 = ext0_q;
      sel1 = ext1_q;
      case (mode_q)
         MODE_TABLE: begin
            sel0 = mem[rp0];
            sel1 = mem[rp1];
         end
         MODE_RAMP: begin
            sel0 = ramp_word(rp0);
            sel1 = ramp_word(rp1);
         end
         default: begin
            sel0 = ext0_q;
            sel1 = ext1_q;
         end
      endcase
   end

   // Stage 1: capture the external words, and register the table read or ramp value.
   always_ff @(posedge adc_clk_i) begin
      if (!adc_rstn_i) begin
         ext0_q  <= '0;
         ext1_q  <= '0;
         s1_dat0 <= '0;
         s1_dat1 <= '0;
         s1_vld  <= 1'b0;
      end else begin
         ext0_q  <= ext_dat0_i;
         ext1_q  <= ext_dat1_i;
         s1_dat0 <= sel0;
         s1_dat1 <= sel1;
         s1_vld  <= (state == ST_RUN);
      end
   end

   // Stage 2: output register. Data is coded, then forced to zero when the sample is not valid.
   always_ff @(posedge adc_clk_i) begin
      if (!adc_rstn_i) begin
         dat0_q <= '0;
         dat1_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         dat0_q <= s1_vld ? line_code(s1_dat0) : '0;
         dat1_q <= s1_vld ? line_code(s1_dat1) : '0;
         vld_q  <= s1_vld;
      end
   end

   assign dat0_o    = dat0_q;
   assign dat1_o    = dat1_q;
   assign dat_vld_o = vld_q;

endmodule

// File: tb/tb_adc_pattern_seq.sv
// Purpose: self-checking bench for adc_pattern_seq, using table-driven run vectors and a sample scoreboard.
// Latency: expects first samples 2 edges after the trigger edge and drain 2 edges after RUN ends.
// Backpressure: none in the DUT. The bench drives at posedge+1 and samples at negedge.
`timescale 1ns/1ps
module tb_adc_pattern_seq;
   localparam int DW = 14;
   localparam int AW = 10;
   localparam int LW = 16;

   logic          adc_clk_i = 1'b0;
   logic          adc_rstn_i = 1'b0;
   logic [1:0]    cfg_mode_i = '0;
   logic [AW-1:0] cfg_len_i = '0;
   logic [AW-1:0] cfg_ofs0_i = '0;
   logic [AW-1:0] cfg_ofs1_i = '0;
   logic [LW-1:0] cfg_loops_i = '0;
   logic          start_i = 1'b0;
   logic          trig_i = 1'b0;
   logic          stop_i = 1'b0;
   logic          tbl_we_i = 1'b0;
   logic [AW-1:0] tbl_addr_i = '0;
   logic [DW-1:0] tbl_wdata_i = '0;
   logic [DW-1:0] ext_dat0_i = '0;
   logic [DW-1:0] ext_dat1_i = '0;
   logic [DW-1:0] dat0_o;
   logic [DW-1:0] dat1_o;
   logic          dat_vld_o;
   logic          busy_o;
   logic          done_o;

   adc_pattern_seq #(.DW(DW), .AW(AW), .LW(LW)) dut (
      .adc_clk_i   (adc_clk_i),
      .adc_rstn_i  (adc_rstn_i),
      .cfg_mode_i  (cfg_mode_i),
      .cfg_len_i   (cfg_len_i),
      .cfg_ofs0_i  (cfg_ofs0_i),
      .cfg_ofs1_i  (cfg_ofs1_i),
      .cfg_loops_i (cfg_loops_i),
      .start_i     (start_i),
      .trig_i      (trig_i),
      .stop_i      (stop_i),
      .tbl_we_i    (tbl_we_i),
      .tbl_addr_i  (tbl_addr_i),
      .tbl_wdata_i (tbl_wdata_i),
      .ext_dat0_i  (ext_dat0_i),
      .ext_dat1_i  (ext_dat1_i),
      .dat0_o      (dat0_o),
      .dat1_o      (dat1_o),
      .dat_vld_o   (dat_vld_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 adc_clk_i = ~adc_clk_i;

   typedef struct {
      string         name;
      logic [1:0]    mode;
      int            len;
      int            ofs0;
      int            ofs1;
      int            loops;
      int            stop_at;
      int            wr_j;
      int            wr_addr;
      int            wr_data;
      int            exp_cnt;
      logic [DW-1:0] exp_f0;
      logic [DW-1:0] exp_f1;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
   } samp_t;

   samp_t         exp_q[$];
   samp_t         mon_e;
   vec_t          vecs[9];
   logic [DW-1:0] tbl_model [2**AW];

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            vld_cnt = 0;
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            first_vld_cyc = -1;
   int            last_vld_cyc = -1;
   logic [DW-1:0] first_d0 = '0;
   logic [DW-1:0] first_d1 = '0;
   bit            vld_prev = 1'b0;
   bit            mon_en = 1'b0;

   function automatic vec_t mk(input string n, input logic [1:0] m, input int len, input int o0,
                               input int o1, input int loops, input int stop_at, input int wr_j,
                               input int wr_addr, input int wr_data, input int cnt,
                               input logic [DW-1:0] f0v, input logic [DW-1:0] f1v);
      vec_t v;
      v.name = n; v.mode = m; v.len = len; v.ofs0 = o0; v.ofs1 = o1; v.loops = loops;
      v.stop_at = stop_at; v.wr_j = wr_j; v.wr_addr = wr_addr; v.wr_data = wr_data;
      v.exp_cnt = cnt; v.exp_f0 = f0v; v.exp_f1 = f1v;
      return v;
   endfunction

   function automatic logic [DW-1:0] enc(input logic [DW-1:0] d);
`ifdef ADC_PAT_INV_EN
      enc = {d[DW-1], ~d[DW-2:0]};
`else
      enc = d;
`endif
   endfunction

   // External stimulus words, indexed by edges since the trigger edge.
   function automatic logic [DW-1:0] f0(input int j);
      f0 = 14'h1ABC + DW'(j * 7);
   endfunction

   function automatic logic [DW-1:0] f1(input int j);
      f1 = 14'h0123 ^ DW'(j);
   endfunction

   function automatic logic [DW-1:0] exp_val(input vec_t c, input int a, input int i, input bit ch);
      case (c.mode)
         2'b01: begin
            // sample i reads the table on edge trig+1+i; a write on edge trig+wr_j lands after that read
            if (c.wr_j != 0 && a == c.wr_addr && (i + 1) > c.wr_j) exp_val = DW'(c.wr_data);
            else exp_val = tbl_model[a];
         end
         2'b10:   exp_val = DW'(a);
         default: exp_val = ch ? f1(i) : f0(i);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge adc_clk_i);
      #1;
   endtask

   always @(posedge adc_clk_i) cyc <= cyc + 1;

   // Output monitor. It pops the scoreboard on each valid sample, and checks zero data when not valid.
   always @(negedge adc_clk_i) begin
      if (mon_en) begin
         if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         checks++;
         if (dat_vld_o === 1'b1) begin
            if (!vld_prev) begin
               first_vld_cyc = cyc;
               first_d0 = dat0_o;
               first_d1 = dat1_o;
            end
            last_vld_cyc = cyc;
            vld_cnt++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_sample cyc=%0d got=%h/%h required=none", cyc, dat0_o, dat1_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (dat0_o !== mon_e.d0 || dat1_o !== mon_e.d1) begin
                  failures++;
                  $display("FAIL sample cyc=%0d got=%h/%h required=%h/%h", cyc, dat0_o, dat1_o,
                           mon_e.d0, mon_e.d1);
               end
            end
         end else if (dat0_o !== '0 || dat1_o !== '0) begin
            failures++;
            $display("FAIL idle_zero cyc=%0d got=%h/%h required=0/0", cyc, dat0_o, dat1_o);
         end
         vld_prev = (dat_vld_o === 1'b1);
      end
   end

   task automatic run_case(input vec_t c);
      int o0;
      int o1;
      int trig_cyc;
      samp_t s;
      o0 = (c.ofs0 >= c.len) ? 0 : c.ofs0;
      o1 = (c.ofs1 >= c.len) ? 0 : c.ofs1;
      for (int i = 0; i < c.exp_cnt; i++) begin
         s.d0 = enc(exp_val(c, (o0 + i) % c.len, i, 1'b0));
         s.d1 = enc(exp_val(c, (o1 + i) % c.len, i, 1'b1));
         exp_q.push_back(s);
      end
      vld_cnt = 0;
      done_cnt = 0;
      first_vld_cyc = -1;
      cfg_mode_i = c.mode;
      cfg_len_i = AW'(c.len);
      cfg_ofs0_i = AW'(c.ofs0);
      cfg_ofs1_i = AW'(c.ofs1);
      cfg_loops_i = LW'(c.loops);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk({c.name, "_armed_busy"}, busy_o, 1);
      ext_dat0_i = f0(0);
      ext_dat1_i = f1(0);
      trig_i = 1'b1;
      tick();
      trig_i = 1'b0;
      trig_cyc = cyc;
      for (int j = 1; j < 400; j++) begin
         ext_dat0_i = f0(j);
         ext_dat1_i = f1(j);
         stop_i = (c.stop_at != 0 && j == c.stop_at);
         tbl_we_i = (c.wr_j != 0 && j == c.wr_j);
         tbl_addr_i = AW'(c.wr_addr);
         tbl_wdata_i = DW'(c.wr_data);
         tick();
         stop_i = 1'b0;
         tbl_we_i = 1'b0;
         if (done_cnt != 0 && cyc >= done_cyc + 4) break;
      end
      chk({c.name, "_done_pulses"}, done_cnt, 1);
      chk({c.name, "_sample_count"}, vld_cnt, c.exp_cnt);
      chk({c.name, "_first_latency"}, first_vld_cyc - trig_cyc, 2);
      chk({c.name, "_done_timing"}, done_cyc - trig_cyc, c.exp_cnt);
      chk({c.name, "_drain"}, last_vld_cyc - done_cyc, 1);
      chk({c.name, "_busy_end"}, busy_o, 0);
      chk({c.name, "_sb_empty"}, exp_q.size(), 0);
      chk({c.name, "_first_d0"}, first_d0, enc(c.exp_f0));
      chk({c.name, "_first_d1"}, first_d1, enc(c.exp_f1));
      if (c.wr_j != 0) tbl_model[c.wr_addr] = DW'(c.wr_data);
      exp_q.delete();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk("tbl_basic",   2'b01, 8, 0, 5, 2,  0, 0, 0, 0,       16, 14'd0,    14'd15);
      vecs[1] = mk("tbl_ofs_ovf", 2'b01, 8, 9, 2, 1,  0, 0, 0, 0,        8, 14'd0,    14'd6);
      vecs[2] = mk("tbl_stop3",   2'b01, 8, 1, 7, 0,  3, 0, 0, 0,        3, 14'd3,    14'd21);
      vecs[3] = mk("ramp_inf",    2'b10, 4, 0, 1, 0, 10, 0, 0, 0,       10, 14'd0,    14'd1);
      vecs[4] = mk("ramp_len1",   2'b10, 1, 0, 0, 3,  0, 0, 0, 0,        3, 14'd0,    14'd0);
      vecs[5] = mk("ramp_ofs",    2'b10, 5, 0, 5, 2,  0, 0, 0, 0,       10, 14'd0,    14'd0);
      vecs[6] = mk("pass00",      2'b00, 3, 0, 0, 2,  0, 0, 0, 0,        6, 14'h1ABC, 14'h0123);
      vecs[7] = mk("pass11",      2'b11, 4, 0, 0, 0,  5, 0, 0, 0,        5, 14'h1ABC, 14'h0123);
      vecs[8] = mk("tbl_rdfirst", 2'b01, 8, 0, 4, 1,  0, 3, 2, 16'h3FFF, 8, 14'd0,    14'd12);

      // reset held, then released with no stimulus
      repeat (3) tick();
      mon_en = 1'b1;
      chk("rst_vld", dat_vld_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_dat0", dat0_o, 0);
      adc_rstn_i = 1'b1;
      repeat (4) begin
         tick();
         chk("idle_busy", busy_o, 0);
         chk("idle_vld", dat_vld_o, 0);
         chk("idle_done", done_o, 0);
      end
      chk("rst_no_done", done_cnt, 0);

      // table fill: tbl[i] = i*3
      for (int i = 0; i < 2**AW; i++) begin
         tbl_we_i = 1'b1;
         tbl_addr_i = AW'(i);
         tbl_wdata_i = DW'(i * 3);
         tbl_model[i] = DW'(i * 3);
         tick();
      end
      tbl_we_i = 1'b0;

      for (int v = 0; v < 9; v++) run_case(vecs[v]);

      // len = 0 arm request is ignored
      vld_cnt = 0;
      done_cnt = 0;
      cfg_mode_i = 2'b01;
      cfg_len_i = '0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("len0_busy", busy_o, 0);
      trig_i = 1'b1;
      tick();
      trig_i = 1'b0;
      repeat (3) tick();
      chk("len0_no_samples", vld_cnt, 0);
      chk("len0_no_done", done_cnt, 0);

      // start and stop together in IDLE: stop wins
      cfg_len_i = AW'(8);
      start_i = 1'b1;
      stop_i = 1'b1;
      tick();
      start_i = 1'b0;
      stop_i = 1'b0;
      chk("startstop_busy", busy_o, 0);
      trig_i = 1'b1;
      tick();
      trig_i = 1'b0;
      repeat (3) tick();
      chk("startstop_no_samples", vld_cnt, 0);

      // stop while ARMED returns to IDLE with no done pulse
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("armstop_busy_armed", busy_o, 1);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      chk("armstop_busy_idle", busy_o, 0);
      trig_i = 1'b1;
      tick();
      trig_i = 1'b0;
      repeat (3) tick();
      chk("armstop_no_done", done_cnt, 0);
      chk("armstop_no_samples", vld_cnt, 0);

      // reset in the middle of a ramp run
      cfg_mode_i = 2'b10;
      cfg_len_i = AW'(4);
      cfg_ofs0_i = '0;
      cfg_ofs1_i = '0;
      cfg_loops_i = '0;
      for (int i = 0; i < 40; i++) begin
         mon_e.d0 = enc(DW'(i % 4));
         mon_e.d1 = enc(DW'(i % 4));
         exp_q.push_back(mon_e);
      end
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      trig_i = 1'b1;
      tick();
      trig_i = 1'b0;
      repeat (6) tick();
      chk("midrun_vld_before", dat_vld_o, 1);
      adc_rstn_i = 1'b0;
      tick();
      exp_q.delete();
      chk("midrun_rst_vld", dat_vld_o, 0);
      chk("midrun_rst_dat0", dat0_o, 0);
      chk("midrun_rst_dat1", dat1_o, 0);
      chk("midrun_rst_busy", busy_o, 0);
      adc_rstn_i = 1'b1;
      repeat (3) tick();
      chk("midrun_no_done", done_cnt, 0);

      // the table contents survive reset
      run_case(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
